// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: CPU push port, status and uart_tx handshake of the transmit FIFO.
interface uart_tx_fifo_if #(parameter int AW = 4);
  logic [7:0] wr_data;
  logic wr_en;
  logic clr_ovf;
  logic full;
  logic empty;
  logic [AW:0] count;
  logic overflow;
  logic [7:0] tx_data;
  logic tx_data_valid;
  logic tx_ready;
  modport master (
    output wr_data, wr_en, clr_ovf, tx_ready,
    input full, empty, count, overflow, tx_data, tx_data_valid
  );
  modport slave (
    input wr_data, wr_en, clr_ovf, tx_ready,
    output full, empty, count, overflow, tx_data, tx_data_valid
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through byte FIFO feeding uart_tx, with sticky overflow.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input logic clk,
  input logic rst,
  uart_tx_fifo_if.slave bus
);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic overflow_q, overflow_d;
  logic full, empty, push, pop;
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  // Push is gated by the registered full only, so a same-cycle pop never frees a slot.
  assign push = bus.wr_en && !full;
  assign pop = !empty && bus.tx_ready;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
    overflow_d = (bus.wr_en && full) ? 1'b1 : bus.clr_ovf ? 1'b0 : overflow_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.wr_data;
  end
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.count = count_q;
  assign bus.overflow = overflow_q;
  assign bus.tx_data = mem[rd_ptr_q];
  assign bus.tx_data_valid = !empty;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and random stimulus checked against a queue model of the FIFO.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n = 0;
  int errs = 0;
  logic [7:0] q[$];
  logic ovf = 1'b0;
  uart_tx_fifo_if #(.AW(4)) bus();
  uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_state();
    int sz = q.size();
    chk("count", 32'(bus.count), 32'(sz));
    chk("empty", 32'(bus.empty), 32'(sz == 0));
    chk("full", 32'(bus.full), 32'(sz == 16));
    chk("valid", 32'(bus.tx_data_valid), 32'(sz != 0));
    chk("overflow", 32'(bus.overflow), 32'(ovf));
    if (sz > 0) chk("tx_data", 32'(bus.tx_data), 32'(q[0]));
  endtask
  task automatic step(input logic we, input logic [7:0] wd, input logic rdy, input logic clr);
    int sz = q.size();
    bus.wr_en = we;
    bus.wr_data = wd;
    bus.tx_ready = rdy;
    bus.clr_ovf = clr;
    if (rdy && sz > 0) void'(q.pop_front());
    if (we && sz < 16) q.push_back(wd);
    ovf = (we && sz == 16) ? 1'b1 : clr ? 1'b0 : ovf;
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask
  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.tx_ready = 1'b0;
    bus.clr_ovf = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_state();
    rst = 1'b0;
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    bus.tx_ready = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    q.delete();
    ovf = 1'b0;
    #1 check_state();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(3) != 0), 8'($urandom), 1'($urandom_range(1)),
           1'($urandom_range(15) == 0));
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO between the CPU's UART transmit port and the `uart_tx` serializer. The CPU pushes bytes at full clock rate; the block presents them first-word-fall-through to `uart_tx` under a valid/ready handshake, so software can queue a message without polling per byte. It also provides full/empty/count status and a sticky overflow flag for the CPU's status register.

## Interface
Parameters:
- `DEPTH`, 16: number of byte entries. Must be a power of two, at least 2.
- `AW`, 4: pointer width, equal to log2(DEPTH).

Ports:
- `clk`  in  1: system clock, 100 MHz.
- `rst`  in  1: asynchronous, active-high reset.
- `wr_data`  in  8: byte from the CPU.
- `wr_en`  in  1: push request, one byte per cycle high.
- `clr_ovf`  in  1: clears the `overflow` flag.
- `full`  out  1: FIFO holds DEPTH bytes.
- `empty`  out  1: FIFO holds 0 bytes.
- `count`  out  AW+1: number of bytes stored, 0..DEPTH.
- `overflow`  out  1: sticky; a push was dropped.
- `tx_data`  out  8: head byte to `uart_tx`.
- `tx_data_valid`  out  1: head byte is valid (equals `!empty`).
- `tx_ready`  in  1: `uart_tx` is idle and can accept a byte.

## Operation
- Storage: DEPTH×8 array. `wr_ptr` and `rd_ptr` are AW bits and wrap modulo DEPTH. `count` is a separate AW+1-bit register.
- Push:
  - Accepted when `wr_en && !full`, using the registered `full` of that cycle.
  - An accepted push writes `mem[wr_ptr]` and increments `wr_ptr`.
  - A push is never accepted while `full` is high, even if a pop happens in the same cycle.
- Pop:
  - Occurs when `tx_data_valid && tx_ready`.
  - It increments `rd_ptr`. Popped data is not cleared from the array.
- `count` update per cycle:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Flags: `full = (count == DEPTH)` and `empty = (count == 0)`, both decoded from registers.
- `tx_data = mem[rd_ptr]` as an asynchronous read. When empty, its value is don't-care; the bench must not check it.
- Overflow:
  - `wr_en && full` sets `overflow` on the next edge.
  - `clr_ovf` clears it on the next edge.
  - If both happen in the same cycle, set wins.
  - A dropped byte does not change any pointer or `count`.
- Simultaneous push and pop:
  - When empty: the push is accepted and there is no pop, because `tx_data_valid` is low.
  - When 0 < count < DEPTH: both complete.
- Reset, asynchronous and usable at any time including mid-transfer:
  - `wr_ptr`, `rd_ptr` and `count` go to 0 and `overflow` goes to 0.
  - Therefore `empty`=1, `full`=0, `tx_data_valid`=0.
  - Array contents are not reset.
  - A byte already latched by `uart_tx` is that block's responsibility.

## Timing
- Write to visible: a push at edge N into an empty FIFO raises `tx_data_valid` in the cycle after edge N, with `tx_data` equal to the pushed byte. Latency is 1 cycle.
- Handshake:
  - `tx_data` is stable while `tx_data_valid` is high and `tx_ready` is low.
  - A pop at edge N presents the next byte, or deasserts valid, in the cycle after edge N.
  - Back-to-back pops are allowed every cycle.
- `full`, `empty` and `count` reflect the state after the most recent edge. There is no combinational path from `wr_en` to them.
- Combinational paths are limited to `tx_data` from `rd_ptr`, and to `tx_data_valid` from the registered count.
- No combinational path from `tx_ready` to any output.

## Test plan
- Reset and single byte:
  - While `rst`=1: `empty`=1, `count`=0, `tx_data_valid`=0, `overflow`=0.
  - Release reset, push 0x41 with `tx_ready`=0.
  - Next cycle: `tx_data_valid`=1, `tx_data`=0x41, `count`=1.
  - Then assert `tx_ready` for one cycle: `empty`=1.
- Fill and overflow:
  - With `tx_ready`=0, push 0x00..0x0F.
  - Expect `full`=1, `count`=16.
  - Push 0xAA: `overflow`=1 next cycle, `count` stays 16.
  - Drain: output sequence is exactly 0x00..0x0F; 0xAA never appears.
  - Pulse `clr_ovf`: `overflow`=0.
- Wrap-around:
  - Push 12, pop 12, then push 10 bytes 0x80..0x89.
  - Pointers cross index 15→0; drain yields 0x80..0x89 in order.
- Simultaneous push and pop:
  - With `count`=5 and `tx_ready`=1 held, push every cycle for 20 cycles.
  - `count` stays 5 and output order matches input order.
  - With the FIFO full, `wr_en` and `tx_ready` both high: one pop, no push, `count` goes 16→15, `overflow`=1.
- Reset mid-operation:
  - With `count`=7, assert `rst` asynchronously between clock edges.
  - `tx_data_valid` drops before the next edge and `count`=0.
  - After release, push 0x55: it appears as the head byte one cycle later.
- Random soak:
  - 10k cycles of random `wr_en` and `tx_ready`, checked against a scoreboard queue model.
  - No loss, duplication or reordering.
  - `overflow` is set exactly on dropped pushes.
